// File: rtl/zstr_skid.sv
// ---------------------------------------------------------------------------
// zstr_skid
//   Fully registered two-entry skid buffer for the zstr valid/ack stream.
//   Every output comes straight from a flop, so no combinational path runs
//   from any input to any output. Sustains one transfer per cycle.
//
// Ports
//   z_clk   : system clock
//   z_rst   : asynchronous active-high reset
//   z_clr   : synchronous flush; has priority over every transition
//   zi_vld  : producer valid
//   zi_bus  : producer data [BW-1:0]
//   zi_ack  : acknowledge to producer (flop)
//   zo_vld  : valid to consumer (flop)
//   zo_bus  : data to consumer [BW-1:0] (flops)
//   zo_ack  : consumer acknowledge
//   lvl     : occupancy 0/1/2; this is also the FSM state encoding
//
// Handshake: on both ports a transfer completes on a rising z_clk edge
// where vld and ack are both 1. zi_ack may be 1 while zi_vld is 0; zo_bus
// is held while zo_vld=1 and zo_ack=0.
// ---------------------------------------------------------------------------
module zstr_skid #(
  parameter int BW = 8
) (
  input  logic          z_clk,
  input  logic          z_rst,
  input  logic          z_clr,
  input  logic          zi_vld,
  input  logic [BW-1:0] zi_bus,
  output logic          zi_ack,
  output logic          zo_vld,
  output logic [BW-1:0] zo_bus,
  input  logic          zo_ack,
  output logic [1:0]    lvl
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_zi_ack;
  logic          r_zo_vld;
  logic [BW-1:0] r_out;
  logic [BW-1:0] r_skid;

  logic w_in;
  logic w_out;
  logic w_out_ld_in;    // output slot <- zi_bus
  logic w_out_ld_skid;  // output slot <- skid slot
  logic w_skid_ld;      // skid slot <- zi_bus

  assign w_in  = zi_vld & r_zi_ack;
  assign w_out = r_zo_vld & zo_ack;

  always_comb begin
    w_state_nxt   = r_state;
    w_out_ld_in   = 1'b0;
    w_out_ld_skid = 1'b0;
    w_skid_ld     = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in) begin
          w_out_ld_in = 1'b1;
          w_state_nxt = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_in && w_out) begin
          w_out_ld_in = 1'b1;
        end else if (w_in) begin
          w_skid_ld   = 1'b1;
          w_state_nxt = ST_FULL;
        end else if (w_out) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_out) begin
          w_out_ld_skid = 1'b1;
          w_state_nxt   = ST_ONE;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
    // Flush wins: any word accepted this cycle is dropped, and zo_bus is
    // left untouched because it is don't-care once zo_vld falls.
    if (z_clr) begin
      w_state_nxt   = ST_EMPTY;
      w_out_ld_in   = 1'b0;
      w_out_ld_skid = 1'b0;
      w_skid_ld     = 1'b0;
    end
  end

  // The ack/valid flops are loaded from the next state so they are
  // already correct for the cycle following the edge.
  always_ff @(posedge z_clk or posedge z_rst) begin
    if (z_rst) begin
      r_state  <= ST_EMPTY;
      r_zi_ack <= 1'b1;
      r_zo_vld <= 1'b0;
      r_out    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_zi_ack <= (w_state_nxt != ST_FULL);
      r_zo_vld <= (w_state_nxt != ST_EMPTY);
      if (w_out_ld_in) begin
        r_out <= zi_bus;
      end else if (w_out_ld_skid) begin
        r_out <= r_skid;
      end
    end
  end

  // Skid slot carries no reset; it is only read in FULL, after a write.
  always_ff @(posedge z_clk) begin
    if (w_skid_ld) begin
      r_skid <= zi_bus;
    end
  end

  assign zi_ack = r_zi_ack;
  assign zo_vld = r_zo_vld;
  assign zo_bus = r_out;
  assign lvl    = r_state;

endmodule

// File: tb/tb_zstr_skid.sv
module tb_zstr_skid;

  logic       z_clk;
  logic       z_rst;
  logic       z_clr;
  logic       zi_vld;
  logic [7:0] zi_bus;
  logic       zi_ack;
  logic       zo_vld;
  logic [7:0] zo_bus;
  logic       zo_ack;
  logic [1:0] lvl;

  int n_checks = 0;
  int n_errors = 0;

  zstr_skid #(.BW(8)) dut (
    .z_clk  (z_clk),
    .z_rst  (z_rst),
    .z_clr  (z_clr),
    .zi_vld (zi_vld),
    .zi_bus (zi_bus),
    .zi_ack (zi_ack),
    .zo_vld (zo_vld),
    .zo_bus (zo_bus),
    .zo_ack (zo_ack),
    .lvl    (lvl)
  );

  // ---- clock ----
  initial begin
    z_clk = 1'b0;
    forever #5 z_clk = ~z_clk;
  end

  // ---- vector table ----
  typedef struct {
    logic       vld;
    logic [7:0] bus;
    logic       ack;
    logic       clr;
    logic       e_zi_ack;
    logic       e_zo_vld;
    logic [1:0] e_lvl;
    logic       bus_chk;
    logic [7:0] e_bus;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic vld, logic [7:0] bus, logic ack, logic clr,
                              logic e_zi_ack, logic e_zo_vld, logic [1:0] e_lvl,
                              logic bus_chk, logic [7:0] e_bus);
    vec_t v;
    v.vld = vld; v.bus = bus; v.ack = ack; v.clr = clr;
    v.e_zi_ack = e_zi_ack; v.e_zo_vld = e_zo_vld; v.e_lvl = e_lvl;
    v.bus_chk = bus_chk; v.e_bus = e_bus;
    return v;
  endfunction

  // ---- scoreboard helpers ----
  logic [7:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge z_clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic e_zi_ack, input logic e_zo_vld,
                          input logic [1:0] e_lvl);
    chk({tag, "_zi_ack"}, 32'(zi_ack), 32'(e_zi_ack));
    chk({tag, "_zo_vld"}, 32'(zo_vld), 32'(e_zo_vld));
    chk({tag, "_lvl"},    32'(lvl),    32'(e_lvl));
  endtask

  initial begin
    // idle (2 rows)
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 2'd0, 1, 8'h00));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 2'd0, 1, 8'h00));
    // skid fill and drain
    vecs.push_back(mk(1, 8'h01, 0, 0, 1, 1, 2'd1, 1, 8'h01));
    vecs.push_back(mk(1, 8'h02, 0, 0, 0, 1, 2'd2, 1, 8'h01));
    vecs.push_back(mk(1, 8'h03, 0, 0, 0, 1, 2'd2, 1, 8'h01));
    vecs.push_back(mk(1, 8'h03, 1, 0, 1, 1, 2'd1, 1, 8'h02));
    vecs.push_back(mk(1, 8'h03, 1, 0, 1, 1, 2'd1, 1, 8'h03));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 0, 2'd0, 1, 8'h03));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 2'd0, 1, 8'h03));
    // flush from FULL holding AA/BB while CC offered
    vecs.push_back(mk(1, 8'hAA, 0, 0, 1, 1, 2'd1, 1, 8'hAA));
    vecs.push_back(mk(1, 8'hBB, 0, 0, 0, 1, 2'd2, 1, 8'hAA));
    vecs.push_back(mk(1, 8'hCC, 0, 1, 1, 0, 2'd0, 0, 8'h00));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 0, 2'd0, 0, 8'h00));
    // flush while an input and an output transfer both complete
    vecs.push_back(mk(1, 8'h11, 0, 0, 1, 1, 2'd1, 1, 8'h11));
    vecs.push_back(mk(1, 8'h22, 1, 1, 1, 0, 2'd0, 0, 8'h00));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 0, 2'd0, 0, 8'h00));
    vecs.push_back(mk(1, 8'h33, 1, 0, 1, 1, 2'd1, 1, 8'h33));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 0, 2'd0, 1, 8'h33));
  end

  // ---- main test ----
  initial begin
    logic [7:0] cur_word;
    logic [7:0] hold_bus;
    logic       hold_chk;
    logic       do_in;
    logic       do_out;
    int         sent;
    int         rcvd;

    z_rst  = 1'b0;
    z_clr  = 1'b0;
    zi_vld = 1'b0;
    zi_bus = 8'h00;
    zo_ack = 1'b0;

    // Reset asserted mid-cycle takes effect immediately
    #12;
    z_rst = 1'b1;
    #1;
    chk_outs("reset", 1'b1, 1'b0, 2'd0);
    chk("reset_bus", 32'(zo_bus), 32'h0);
    step();
    z_rst = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      zi_vld = vecs[i].vld;
      zi_bus = vecs[i].bus;
      zo_ack = vecs[i].ack;
      z_clr  = vecs[i].clr;
      step();
      chk_outs($sformatf("vec%0d", i), vecs[i].e_zi_ack, vecs[i].e_zo_vld, vecs[i].e_lvl);
      if (vecs[i].bus_chk)
        chk($sformatf("vec%0d_bus", i), 32'(zo_bus), 32'(vecs[i].e_bus));
    end
    z_clr = 1'b0;

    // Streaming 0x01..0x10 with zo_ack held high
    zo_ack = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      zi_vld = 1'b1;
      zi_bus = 8'(i);
      step();
      chk_outs($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1);
      chk($sformatf("stream%0d_bus", i), 32'(zo_bus), 32'(i));
    end
    zi_vld = 1'b0;
    step();
    chk_outs("stream_end", 1'b1, 1'b0, 2'd0);

    // Random backpressure with scoreboard
    sent     = 0;
    rcvd     = 0;
    cur_word = 8'($urandom);
    for (int cyc = 0; cyc < 20000 && rcvd < 1000; cyc++) begin
      zi_vld   = (sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      zi_bus   = cur_word;
      zo_ack   = 1'($urandom_range(0, 1));
      do_in    = zi_vld & zi_ack;
      do_out   = zo_vld & zo_ack;
      hold_chk = zo_vld & ~zo_ack;
      hold_bus = zo_bus;
      if (do_out) begin
        chk("rand_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0)
          chk("rand_data", 32'(zo_bus), 32'(exp_q.pop_front()));
        rcvd++;
      end
      if (do_in) begin
        exp_q.push_back(cur_word);
        sent++;
        cur_word = 8'($urandom);
      end
      step();
      chk("rand_lvl", 32'(lvl), 32'(exp_q.size()));
      chk("rand_zo_vld", 32'(zo_vld), 32'(exp_q.size() != 0));
      chk("rand_zi_ack", 32'(zi_ack), 32'(exp_q.size() != 2));
      if (hold_chk) begin
        chk("rand_hold_vld", 32'(zo_vld), 32'd1);
        chk("rand_hold_bus", 32'(zo_bus), 32'(hold_bus));
      end
    end
    chk("rand_sent", 32'(sent), 32'd1000);
    chk("rand_rcvd", 32'(rcvd), 32'd1000);
    zi_vld = 1'b0;
    zo_ack = 1'b0;
    step();
    chk_outs("rand_idle", 1'b1, 1'b0, 2'd0);

    // Clear and reset collision, with a stored word discarded by reset
    zi_vld = 1'b1;
    zi_bus = 8'h77;
    step();
    chk_outs("coll_load", 1'b1, 1'b1, 2'd1);
    chk("coll_load_bus", 32'(zo_bus), 32'h77);
    zi_vld = 1'b0;
    z_clr  = 1'b1;
    #2;
    z_rst  = 1'b1;
    #1;
    chk_outs("coll_rst", 1'b1, 1'b0, 2'd0);
    chk("coll_rst_bus", 32'(zo_bus), 32'h0);
    step();
    z_rst = 1'b0;
    step();
    chk_outs("coll_clr", 1'b1, 1'b0, 2'd0);
    chk("coll_clr_bus", 32'(zo_bus), 32'h0);
    z_clr  = 1'b0;
    zi_vld = 1'b1;
    zi_bus = 8'h55;
    step();
    chk_outs("coll_55", 1'b1, 1'b1, 2'd1);
    chk("coll_55_bus", 32'(zo_bus), 32'h55);
    zi_vld = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
